axil_slave_mem: RTL and testbench
=================================

// Module: axil_slave_mem
// PURPOSE
// - AXI-Lite responder (slave) fronting a single-port word memory; the target end of the mem_sys master bus.
// - Accepts AW/W/AR independently, commits byte-strobed writes, returns reads and B/R responses.
// - Sits between the core's AXI-Lite master port and on-chip RAM/MMIO space in sim and FPGA builds.
// PARAMETERS
// - WIDTH       XLEN       data/address width, fixed at 32.
// - DEPTH       1024       memory depth in WIDTH-bit words; power of two.
// - BASE_ADDR   32'h0      byte address of word 0; window = [BASE_ADDR, BASE_ADDR+DEPTH*4).
// PORTS
// - clk             in   1        sole clock
// - rst             in   1        asynchronous, active-high reset
// - s_axil_awaddr   in   WIDTH    write address
// - s_axil_awprot   in   3        ignored
// - s_axil_awvalid  in   1        write address valid
// - s_axil_awready  out  1        write address ready
// - s_axil_wdata    in   WIDTH    write data
// - s_axil_wstrb    in   WIDTH/8  byte strobes
// - s_axil_wvalid   in   1        write data valid
// - s_axil_wready   out  1        write data ready
// - s_axil_bresp    out  2        write response
// - s_axil_bvalid   out  1        write response valid
// - s_axil_bready   in   1        write response ready
// - s_axil_araddr   in   WIDTH    read address
// - s_axil_arprot   in   3        ignored
// - s_axil_arvalid  in   1        read address valid
// - s_axil_arready  out  1        read address ready
// - s_axil_rdata    out  WIDTH    read data
// - s_axil_rresp    out  2        read response
// - s_axil_rvalid   out  1        read data valid
// - s_axil_rready   in   1        read data ready
// BEHAVIOUR
// - All outputs registered. Reset: awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=OKAY, rdata=0;
//   readies rise in the first cycle after rst deasserts. RAM contents are NOT reset.
// - Word index = (addr-BASE_ADDR)>>2; addr[1:0] ignored. Out-of-window -> SLVERR, no RAM access, rdata=0.
// - Write FSM W_IDLE -> W_COMMIT -> W_RESP:
//   W_IDLE: awready=~aw_held, wready=~w_held; AW and W captured independently, in either order or same cycle.
//   Both held -> W_COMMIT: RAM write with wstrb (only strobed bytes change); wstrb=0 -> OKAY, no change.
//   W_RESP: bvalid=1, bresp stable until bready; then W_IDLE, holds cleared, awready/wready=1 next cycle.
//   Latency: AW&W handshake cycle N -> commit N+1 -> bvalid N+2 (no read conflict).
// - Read FSM R_IDLE -> R_MEM -> R_DATA:
//   R_IDLE: arready=1; handshake captures araddr, arready=0 until R_DATA completes.
//   R_MEM: issues RAM read; stalls while W_COMMIT active in same cycle (write wins tie).
//   R_DATA: rvalid=1, rdata/rresp stable until rready; then R_IDLE.
//   Latency: AR cycle N -> rvalid N+2; +1 per write-priority stall.
// - Ordering: read stalled behind a same-address commit returns the newly written data.
// - One outstanding read and one outstanding write max; never interleaves beats of either channel.
// - Backpressure: any bready/rready low cycles hold response unchanged; no combinational ready->valid paths.
// - Reset mid-transaction: transaction abandoned; a write whose commit edge has not occurred does not modify RAM.
// STRUCTURE
// - axi_defines: axil_resp_t (OKAY=2'b00, SLVERR=2'b10), wr_state_t, rd_state_t enums.
// - Sub-module axil_sp_ram: single-port, DEPTH x WIDTH, byte write enables, 1-cycle registered read.
// - Top holds both FSMs, aw/w capture regs, window decode, write-priority arbiter.
// TESTING
// - AW+W same cycle addr 0x10 data 0xDEADBEEF strb 0xF -> bvalid@N+2 OKAY; read 0x10 -> rdata 0xDEADBEEF OKAY.
// - W 3 cycles before AW (addr 0x14, 0x11223344, strb 0x3) over 0xFFFFFFFF -> readback 0xFFFF3344.
// - AR 0x20 while commit to 0x20 (0xCAFEF00D) same cycle -> read stalls 1, rdata 0xCAFEF00D, rvalid@N+3.
// - bready/rready low 5 cycles -> bvalid/rvalid, resp, rdata held; no new AW/W/AR accepted meanwhile.
// - Write/read to BASE_ADDR+DEPTH*4 -> bresp/rresp SLVERR, rdata 0, RAM unchanged (check 0x0 intact).
// - rst pulse between AW/W capture and commit -> all outputs reset values, target word unchanged.

Source files
------------

// File: rtl/axi_defines.sv
// Shared AXI-Lite response codes and FSM state types for the memory responder.
package axi_defines;

  localparam int AXIL_WIDTH = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axil_resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COMMIT,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_MEM,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axil_sp_ram.sv
// Single-port word RAM with byte write enables and a registered read port.
// The read register only changes on a read or clear, so it can drive the R channel directly.
module axil_sp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [WIDTH/8-1:0]       be,
  input  logic                     re,
  input  logic                     clr,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array is deliberately left without a reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WIDTH / 8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/axil_slave_mem.sv
// AXI-Lite responder in front of a single-port word RAM.
// Independent write and read FSMs share the RAM port; a write commit wins any same-cycle conflict.
module axil_slave_mem
  import axi_defines::*;
#(
  parameter int               WIDTH     = AXIL_WIDTH,
  parameter int               DEPTH     = 1024,
  parameter logic [WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   s_axil_awaddr,
  input  logic [2:0]         s_axil_awprot,
  input  logic               s_axil_awvalid,
  output logic               s_axil_awready,
  input  logic [WIDTH-1:0]   s_axil_wdata,
  input  logic [WIDTH/8-1:0] s_axil_wstrb,
  input  logic               s_axil_wvalid,
  output logic               s_axil_wready,
  output logic [1:0]         s_axil_bresp,
  output logic               s_axil_bvalid,
  input  logic               s_axil_bready,
  input  logic [WIDTH-1:0]   s_axil_araddr,
  input  logic [2:0]         s_axil_arprot,
  input  logic               s_axil_arvalid,
  output logic               s_axil_arready,
  output logic [WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]         s_axil_rresp,
  output logic               s_axil_rvalid,
  input  logic               s_axil_rready
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = WIDTH / 8;
  localparam logic [WIDTH-3:0] DEPTH_LIM = (WIDTH-2)'(DEPTH);

  wr_state_t w_state, w_next;
  rd_state_t r_state, r_next;

  logic             aw_held, w_held, aw_held_d, w_held_d;
  logic [WIDTH-1:0] awaddr_q, wdata_q, araddr_q;
  logic [SW-1:0]    wstrb_q;
  logic             aw_hs, w_hs, ar_hs, commit, rd_go;
  logic             awready_d, wready_d, bvalid_d, arready_d, rvalid_d;
  axil_resp_t       bresp_d, rresp_d, bresp_q, rresp_q;
  logic [WIDTH:0]   wr_diff, rd_diff;
  logic             wr_ok, rd_ok;
  logic             ram_we, ram_re, ram_clr;
  logic [AW-1:0]    ram_addr;

  assign aw_hs  = s_axil_awvalid && s_axil_awready;
  assign w_hs   = s_axil_wvalid && s_axil_wready;
  assign ar_hs  = s_axil_arvalid && s_axil_arready;
  assign commit = (w_state == W_COMMIT);
  assign rd_go  = (r_state == R_MEM) && !commit;

  // Extra top bit is the borrow: set when the address lies below BASE_ADDR.
  assign wr_diff = {1'b0, awaddr_q} - {1'b0, BASE_ADDR};
  assign rd_diff = {1'b0, araddr_q} - {1'b0, BASE_ADDR};
  assign wr_ok   = !wr_diff[WIDTH] && (wr_diff[WIDTH-1:2] < DEPTH_LIM);
  assign rd_ok   = !rd_diff[WIDTH] && (rd_diff[WIDTH-1:2] < DEPTH_LIM);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // NOTE: defaults first keep every path assigned, so no latches are inferred.
  always_comb begin
    w_next = w_state;
    r_next = r_state;
    case (w_state)
      W_IDLE:   if ((aw_held || aw_hs) && (w_held || w_hs)) w_next = W_COMMIT;
      W_COMMIT: w_next = W_RESP;
      W_RESP:   if (s_axil_bready) w_next = W_IDLE;
      default:  w_next = W_IDLE;
    endcase
    case (r_state)
      R_IDLE:   if (ar_hs) r_next = R_MEM;
      R_MEM:    if (!commit) r_next = R_DATA;
      R_DATA:   if (s_axil_rready) r_next = R_IDLE;
      default:  r_next = R_IDLE;
    endcase
  end

  // Next values of the registered outputs; holds clear whenever the write FSM leaves idle.
  always_comb begin
    aw_held_d = (w_state == W_IDLE) && (w_next == W_IDLE) && (aw_held || aw_hs);
    w_held_d  = (w_state == W_IDLE) && (w_next == W_IDLE) && (w_held || w_hs);
    awready_d = (w_next == W_IDLE) && !aw_held_d;
    wready_d  = (w_next == W_IDLE) && !w_held_d;
    bvalid_d  = (w_next == W_RESP);
    bresp_d   = bresp_q;
    if (commit) bresp_d = wr_ok ? OKAY : SLVERR;
    arready_d = (r_next == R_IDLE);
    rvalid_d  = (r_next == R_DATA);
    rresp_d   = rresp_q;
    if (rd_go) rresp_d = rd_ok ? OKAY : SLVERR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      awaddr_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      araddr_q       <= '0;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      bresp_q        <= OKAY;
      rresp_q        <= OKAY;
    end else begin
      aw_held        <= aw_held_d;
      w_held         <= w_held_d;
      if (aw_hs) awaddr_q <= s_axil_awaddr;
      if (w_hs) begin
        wdata_q <= s_axil_wdata;
        wstrb_q <= s_axil_wstrb;
      end
      if (ar_hs) araddr_q <= s_axil_araddr;
      s_axil_awready <= awready_d;
      s_axil_wready  <= wready_d;
      s_axil_bvalid  <= bvalid_d;
      s_axil_arready <= arready_d;
      s_axil_rvalid  <= rvalid_d;
      bresp_q        <= bresp_d;
      rresp_q        <= rresp_d;
    end
  end

  assign s_axil_bresp = bresp_q;
  assign s_axil_rresp = rresp_q;

  // Write-priority arbiter: the commit owns the port; a stalled read retries next cycle.
  assign ram_we   = commit && wr_ok;
  assign ram_re   = rd_go && rd_ok;
  assign ram_clr  = rd_go && !rd_ok;
  assign ram_addr = commit ? wr_diff[AW+1:2] : rd_diff[AW+1:2];

  axil_sp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .be    (wstrb_q),
    .re    (ram_re),
    .clr   (ram_clr),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (s_axil_rdata)
  );

  logic unused;
  assign unused = ^{s_axil_awprot, s_axil_arprot, wr_diff[1:0], rd_diff[1:0]};

endmodule

// File: tb/tb_axil_slave_mem.sv
// Self-checking bench for axil_slave_mem: directed protocol scenarios plus randomized
// traffic compared against a word-array reference model.
module tb_axil_slave_mem;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [31:0] model [int];

  axil_slave_mem #(.WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic bit in_win(input logic [31:0] a);
    longint x;
    x = longint'({32'h0, a});
    return (x >= longint'({32'h0, BASE})) && (x < longint'({32'h0, BASE}) + longint'(DEPTH) * 4);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int hold, input string tag);
    int t, hs_edge, lat, w_start, aw_start;
    bit aw_done, w_done, aw_go, w_go;
    logic [1:0]  exp_resp;
    logic [31:0] word;
    exp_resp = in_win(a) ? 2'b00 : 2'b10;
    w_start  = (lead < 0) ? -lead : 0;
    aw_start = (lead > 0) ? lead : 0;
    aw_done = 0; w_done = 0; t = 0; hs_edge = 0;
    @(negedge clk);
    while (!(aw_done && w_done) && t < 40) begin
      if (t >= aw_start && !aw_done) begin awaddr = a; awvalid = 1'b1; end
      if (t >= w_start && !w_done) begin wdata = d; wstrb = s; wvalid = 1'b1; end
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(negedge clk);
      if (aw_go) begin aw_done = 1; awvalid = 1'b0; hs_edge = cyc; end
      if (w_go)  begin w_done = 1;  wvalid = 1'b0;  hs_edge = cyc; end
      t++;
    end
    n_checks++;
    if (!(aw_done && w_done)) begin
      n_errors++; $display("FAIL %s aw_w_accept: got aw=%0b w=%0b want 1 1", tag, aw_done, w_done);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    t = 0;
    while (!bvalid && t < 20) begin @(negedge clk); t++; end
    lat = cyc - hs_edge;
    n_checks++;
    if (!bvalid) begin n_errors++; $display("FAIL %s bvalid_timeout: got 0 want 1", tag); end
    n_checks++;
    if (lat != 1) begin n_errors++; $display("FAIL %s b_latency: got %0d want 1", tag, lat); end
    n_checks++;
    if (bresp !== exp_resp) begin n_errors++; $display("FAIL %s bresp: got %b want %b", tag, bresp, exp_resp); end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_checks++;
      if (bvalid !== 1'b1 || bresp !== exp_resp || awready !== 1'b0 || wready !== 1'b0) begin
        n_errors++;
        $display("FAIL %s b_hold: got bv=%b br=%b awr=%b wr=%b want 1 %b 0 0", tag, bvalid, bresp, awready, wready, exp_resp);
      end
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    n_checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      n_errors++; $display("FAIL %s b_done: got bv=%b awr=%b wr=%b want 0 1 1", tag, bvalid, awready, wready);
    end
    if (exp_resp == 2'b00) begin
      word = model.exists(widx(a)) ? model[widx(a)] : 32'hx;
      for (int i = 0; i < 4; i++) if (s[i]) word[8*i +: 8] = d[8*i +: 8];
      model[widx(a)] = word;
    end
  endtask

  task automatic read_txn(input logic [31:0] a, input int hold, input string tag, output logic [31:0] got);
    int t, hs_edge, lat;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    exp_resp = in_win(a) ? 2'b00 : 2'b10;
    exp_data = !in_win(a) ? 32'h0 : (model.exists(widx(a)) ? model[widx(a)] : 32'hx);
    @(negedge clk);
    araddr = a; arvalid = 1'b1; t = 0;
    while (!arready && t < 40) begin @(negedge clk); t++; end
    n_checks++;
    if (!arready) begin n_errors++; $display("FAIL %s ar_accept: got 0 want 1", tag); end
    @(negedge clk);
    arvalid = 1'b0; hs_edge = cyc; t = 0;
    while (!rvalid && t < 20) begin @(negedge clk); t++; end
    lat = cyc - hs_edge;
    got = rdata;
    n_checks++;
    if (!rvalid) begin n_errors++; $display("FAIL %s rvalid_timeout: got 0 want 1", tag); end
    n_checks++;
    if (lat != 1) begin n_errors++; $display("FAIL %s r_latency: got %0d want 1", tag, lat); end
    n_checks++;
    if (rresp !== exp_resp) begin n_errors++; $display("FAIL %s rresp: got %b want %b", tag, rresp, exp_resp); end
    if (!$isunknown(exp_data)) begin
      n_checks++;
      if (rdata !== exp_data) begin n_errors++; $display("FAIL %s rdata: got %h want %h", tag, rdata, exp_data); end
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_checks++;
      if (rvalid !== 1'b1 || rresp !== exp_resp || rdata !== got || arready !== 1'b0) begin
        n_errors++;
        $display("FAIL %s r_hold: got rv=%b rr=%b rd=%h arr=%b want 1 %b %h 0", tag, rvalid, rresp, rdata, arready, exp_resp, got);
      end
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    n_checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      n_errors++; $display("FAIL %s r_done: got rv=%b arr=%b want 0 1", tag, rvalid, arready);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      n_errors++; $display("FAIL %s rst_handshake: got %b want 00000", tag, {awready, wready, arready, bvalid, rvalid});
    end
    n_checks++;
    if (bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0) begin
      n_errors++; $display("FAIL %s rst_resp: got br=%b rr=%b rd=%h want 00 00 0", tag, bresp, rresp, rdata);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    #1;
    n_checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      n_errors++; $display("FAIL reset readies_before_edge: got %b want 000", {awready, wready, arready});
    end
    @(negedge clk);
    n_checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_errors++; $display("FAIL reset readies_rise: got %b want 111", {awready, wready, arready});
    end
  endtask

  task automatic test_basic;
    logic [31:0] got;
    write_txn(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, "basic_w");
    read_txn(32'h10, 0, "basic_r", got);
    n_checks++;
    if (got !== 32'hDEADBEEF) begin n_errors++; $display("FAIL basic_const: got %h want deadbeef", got); end
  endtask

  task automatic test_strobe;
    logic [31:0] got;
    write_txn(32'h14, 32'hFFFFFFFF, 4'hF, 0, 0, "strb_init");
    write_txn(32'h14, 32'h11223344, 4'h3, 3, 0, "strb_w");
    read_txn(32'h14, 0, "strb_r", got);
    n_checks++;
    if (got !== 32'hFFFF3344) begin n_errors++; $display("FAIL strobe_const: got %h want ffff3344", got); end
    write_txn(32'h14, 32'h0BAD0BAD, 4'h0, -2, 0, "strb0_w");
    read_txn(32'h14, 0, "strb0_r", got);
    n_checks++;
    if (got !== 32'hFFFF3344) begin n_errors++; $display("FAIL strobe_zero: got %h want ffff3344", got); end
  endtask

  task automatic test_conflict;
    int hs_edge, b_at, r_at;
    write_txn(32'h20, 32'h01010101, 4'hF, 0, 0, "conf_init");
    @(negedge clk);
    awaddr = 32'h20; awvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 32'h20; arvalid = 1'b1;
    n_checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_errors++; $display("FAIL conflict_ready: got %b want 111", {awready, wready, arready});
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; hs_edge = cyc;
    b_at = -1; r_at = -1;
    for (int i = 0; i < 8; i++) begin
      if (bvalid && b_at < 0) b_at = cyc - hs_edge;
      if (rvalid && r_at < 0) r_at = cyc - hs_edge;
      @(negedge clk);
    end
    n_checks++;
    if (b_at != 1) begin n_errors++; $display("FAIL conflict_b_latency: got %0d want 1", b_at); end
    n_checks++;
    if (r_at != 2) begin n_errors++; $display("FAIL conflict_r_latency: got %0d want 2", r_at); end
    n_checks++;
    if (rdata !== 32'hCAFEF00D || rresp !== 2'b00 || bresp !== 2'b00) begin
      n_errors++; $display("FAIL conflict_data: got rd=%h rr=%b br=%b want cafef00d 00 00", rdata, rresp, bresp);
    end
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    n_checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
      n_errors++; $display("FAIL conflict_done: got bv=%b rv=%b want 0 0", bvalid, rvalid);
    end
    model[widx(32'h20)] = 32'hCAFEF00D;
  endtask

  task automatic test_backpressure;
    logic [31:0] got;
    write_txn(32'h40, 32'h5A5AA5A5, 4'hF, 0, 5, "bp_w");
    read_txn(32'h40, 5, "bp_r", got);
  endtask

  task automatic test_out_of_window;
    logic [31:0] got;
    write_txn(32'h0, 32'h0BADF00D, 4'hF, 0, 0, "oow_init");
    write_txn(BASE + DEPTH * 4, 32'h55555555, 4'hF, 0, 0, "oow_w");
    read_txn(BASE + DEPTH * 4, 0, "oow_r", got);
    n_checks++;
    if (got !== 32'h0) begin n_errors++; $display("FAIL oow_rdata: got %h want 0", got); end
    read_txn(32'h0, 0, "oow_word0", got);
    n_checks++;
    if (got !== 32'h0BADF00D) begin n_errors++; $display("FAIL oow_intact: got %h want 0badf00d", got); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] got;
    write_txn(32'h30, 32'h12345678, 4'hF, 0, 0, "mid_init");
    read_txn(32'h30, 0, "mid_pre", got);
    @(negedge clk);
    awaddr = 32'h30; awvalid = 1'b1; wdata = 32'hAAAA5555; wstrb = 4'hF; wvalid = 1'b1;
    n_checks++;
    if ({awready, wready} !== 2'b11) begin n_errors++; $display("FAIL mid_ready: got %b want 11", {awready, wready}); end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({awready, wready, arready, bvalid} !== 4'b1110) begin
      n_errors++; $display("FAIL mid_recover: got %b want 1110", {awready, wready, arready, bvalid});
    end
    read_txn(32'h30, 0, "mid_post", got);
    n_checks++;
    if (got !== 32'h12345678) begin n_errors++; $display("FAIL mid_unchanged: got %h want 12345678", got); end
  endtask

  task automatic test_random;
    logic [31:0] a, got;
    int lead, hold;
    for (int i = 0; i < 16; i++) write_txn(BASE + 32'(i * 4), $urandom, 4'hF, 0, 0, "rnd_init");
    repeat (48) begin
      a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? BASE + DEPTH * 4 + 32'($urandom_range(0, 255)) : 32'hFFFF_FFFC;
      lead = int'($urandom_range(0, 4)) - 2;
      hold = int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 0) write_txn(a, $urandom, 4'($urandom), lead, hold, "rnd_w");
      else read_txn(a, hold, "rnd_r", got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_conflict();
    test_backpressure();
    test_out_of_window();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
